fifo_wptr_full_ctrl: RTL and testbench
======================================

// Module: fifo_wptr_full_ctrl
// PURPOSE
//   Write-side controller for the async FIFO. Runs entirely in the write clock domain.
//   - Owns the write pointer (binary + Gray) and drives waddr/wclken into the dual-port
//     FIFO memory.
//   - Computes registered full, almost-full, fill level and a sticky overflow flag from the
//     read pointer after it has been synchronized into wclk.
//   - Its Gray pointer wptr goes to the read-domain 2-FF synchronizer.
// PARAMETERS
//   ADDRSIZE  4  memory address width; DEPTH = 2**ADDRSIZE; must be >= 2
// PORTS
//   wclk         in   1           write clock; all state updates on posedge
//   wrst_n       in   1           asynchronous active-low reset
//   winc         in   1           write request; data is taken on this cycle if not full
//   wq2_rptr     in   ADDRSIZE+1  Gray read pointer, already 2-FF synchronized into wclk
//   afull_thresh in   ADDRSIZE+1  almost-full threshold in entries (0..DEPTH)
//   wclr_ovf     in   1           synchronous clear of the sticky overflow flag
//   waddr        out  ADDRSIZE    binary write address to memory
//   wclken       out  1           memory write enable = winc & ~wfull (combinational)
//   wptr         out  ADDRSIZE+1  registered Gray write pointer, to the read-domain sync
//   wfull        out  1           registered full flag
//   walmost_full out  1           registered; high when level >= afull_thresh
//   wlevel       out  ADDRSIZE+1  registered occupancy (0..DEPTH), pessimistic
//   wovf         out  1           sticky; high after a write was attempted while full
// BEHAVIOUR
//   - Reset: asynchronous, active low. While wrst_n=0, all registers read 0:
//     wbin=0, wptr=0, wfull=0, walmost_full=0, wlevel=0, wovf=0.
//     Reset may assert mid-operation; any in-flight write is abandoned.
//   - Pointer state: wbin[ADDRSIZE:0] and wptr[ADDRSIZE:0] are registered.
//     - waddr = wbin[ADDRSIZE-1:0].
//     - wbinnext  = wbin + (winc & ~wfull), modulo 2**(ADDRSIZE+1).
//     - wgraynext = (wbinnext >> 1) ^ wbinnext.
//     - Each posedge: wbin <= wbinnext, wptr <= wgraynext.
//     - Wrap: after 2*DEPTH accepted writes both pointers return to 0; the extra MSB
//       disambiguates full from empty.
//   - Write latency:
//     - The memory captures wdata on the same edge that advances wbin.
//     - wptr reflects the write one cycle later.
//   - Full flag: registered.
//     - wfull <= (wgraynext == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]}), where A = ADDRSIZE.
//     - The write that fills the last entry raises wfull on the same edge it is accepted.
//   - Read pointer decode: rbin = Gray-to-binary of wq2_rptr (XOR prefix chain, combinational).
//   - Level and almost-full, both registered:
//     - wlevel       <= (wbinnext - rbin) modulo 2**(A+1); result is always 0..DEPTH.
//     - walmost_full <= ((wbinnext - rbin) >= afull_thresh), unsigned compare.
//     - afull_thresh=0 keeps walmost_full high constantly.
//   - Pessimism: wq2_rptr lags real reads by 2-3 wclk. wfull, walmost_full and wlevel may
//     stay high/over-count for that long after a read. They never under-report occupancy.
//   - Write while full: winc=1 with wfull=1 does not move the pointers, wclken=0, and wovf
//     is set on that edge.
//   - Overflow flag: wovf set has priority over wclr_ovf in the same cycle. Otherwise
//     wclr_ovf=1 clears it on the next edge.
//   - Simultaneous events: a write on the same cycle a read-pointer update arrives is
//     handled in one edge; level = new wbinnext minus new rbin.
//   - The memory also gates its write with wfull; wclken already excludes full.
// TESTING (ADDRSIZE=4, DEPTH=16, afull_thresh=14)
//   1 Reset: drive random inputs with wrst_n=0, then release
//     -> all outputs 0 and waddr=0 on the first cycle after release.
//   2 Fill with wq2_rptr=0: 16 consecutive winc
//     -> wlevel counts 1..16; walmost_full rises with the 14th write; wfull rises on the
//        16th write's edge; wptr=5'b11000.
//   3 Overflow: one more winc while full
//     -> wclken=0, waddr unchanged at 0, wovf=1.
//     -> wclr_ovf together with a failed winc keeps wovf=1; wclr_ovf alone then clears it.
//   4 Drain: wq2_rptr steps through Gray 1..16 (reads)
//     -> wfull falls the cycle after wq2_rptr=Gray(1)=00001; wlevel tracks 16-reads.
//   5 Wrap: 40 writes interleaved with matching read-pointer updates
//     -> wbin wraps through 0; wptr changes by exactly one bit per accepted write.
//     -> wfull never false-asserts; wlevel never exceeds 16.
//   6 Mid-op reset: assert wrst_n=0 asynchronously between edges with level=9
//     -> outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_wptr_full_ctrl.sv
// Write-domain half of an async FIFO. It owns the binary/Gray write pointer and derives
// registered full, almost-full, occupancy and sticky overflow from the synchronized read pointer.
module fifo_wptr_full_ctrl #(
    parameter int ADDRSIZE = 4
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic [ADDRSIZE:0]   afull_thresh,
    input  logic                wclr_ovf,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wclken,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);

    localparam int A = ADDRSIZE;

    logic [A:0] wbin;
    logic [A:0] wbinnext;
    logic [A:0] wgraynext;
    logic [A:0] rbin;
    logic [A:0] level_next;
    logic [A:0] full_match;

    // Handshake: winc is a request with no back-pressure wait; wclken marks acceptance,
    // i.e. the memory write and the pointer advance happen only when winc=1 and wfull=0.
    assign wclken    = winc & ~wfull;
    assign waddr     = wbin[A-1:0];
    assign wbinnext  = wbin + {{A{1'b0}}, wclken};
    assign wgraynext = (wbinnext >> 1) ^ wbinnext;

    always_comb begin
        rbin    = '0;
        rbin[A] = wq2_rptr[A];
        for (int i = A - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ wq2_rptr[i];
        end
    end

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign full_match = {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]};
    assign level_next = wbinnext - rbin;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            wovf         <= 1'b0;
        end else begin
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            wfull        <= (wgraynext == full_match);
            walmost_full <= (level_next >= afull_thresh);
            wlevel       <= level_next;
            if (winc && wfull) begin
                wovf <= 1'b1;
            end else if (wclr_ovf) begin
                wovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wptr_full_ctrl.sv
// Bench for fifo_wptr_full_ctrl: directed write/read-pointer sequences, an occupancy model
// that queues per-cycle expectations, and a negedge monitor that pops and compares them.
module tb_fifo_wptr_full_ctrl;

    logic       wclk = 1'b0;
    logic       wrst_n = 1'b0;
    logic       winc = 1'b0;
    logic [4:0] wq2_rptr = '0;
    logic [4:0] afull_thresh = 5'd14;
    logic       wclr_ovf = 1'b0;
    logic [3:0] waddr;
    logic       wclken;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       wovf;

    fifo_wptr_full_ctrl #(.ADDRSIZE(4)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
        .afull_thresh(afull_thresh), .wclr_ovf(wclr_ovf), .waddr(waddr),
        .wclken(wclken), .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full),
        .wlevel(wlevel), .wovf(wovf)
    );

    // ---------------- clock ----------------
    always #5 wclk = ~wclk;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [3:0] waddr;
        logic       wclken;
        logic [4:0] wptr;
        logic       wfull;
        logic       wafull;
        logic [4:0] wlevel;
        logic       wovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic logic [4:0] gray(input int n);
        logic [4:0] b;
        b = 5'(n);
        return b ^ (b >> 1);
    endfunction

    // Occupancy model: counts of accepted writes and reads, and the registered outputs
    // the DUT should present after the most recent edge.
    int         m_w, m_rd, thr_cfg;
    logic       e_full, e_af, e_ovf;
    logic [4:0] e_wptr, e_level;

    task automatic reset_model();
        m_w = 0; m_rd = 0;
        e_full = 0; e_af = 0; e_ovf = 0; e_wptr = '0; e_level = '0;
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic w, input int rd, input logic clr);
        exp_t e;
        int   lvl;
        @(posedge wclk);
        #1;
        winc = w;
        wq2_rptr = gray(rd);
        wclr_ovf = clr;
        afull_thresh = 5'(thr_cfg);
        e.waddr  = 4'(m_w % 16);
        e.wclken = w & ~e_full;
        e.wptr   = e_wptr;
        e.wfull  = e_full;
        e.wafull = e_af;
        e.wlevel = e_level;
        e.wovf   = e_ovf;
        exp_q.push_back(e);
        if (w && e_full) e_ovf = 1'b1;
        else if (clr)    e_ovf = 1'b0;
        if (w && !e_full) m_w++;
        m_rd = rd;
        lvl = m_w - m_rd;
        e_level = 5'(lvl);
        e_full  = (lvl == 16);
        e_af    = (lvl >= thr_cfg);
        e_wptr  = gray(m_w);
    endtask

    // ---------------- monitor ----------------
    logic [4:0] prev_wptr = '0;
    bit         prev_ok = 0;

    always @(negedge wclk) begin
        exp_t e;
        if (!wrst_n) begin
            prev_ok = 0;
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("waddr", int'(waddr), int'(e.waddr));
                chk("wclken", int'(wclken), int'(e.wclken));
                chk("wptr", int'(wptr), int'(e.wptr));
                chk("wfull", int'(wfull), int'(e.wfull));
                chk("walmost_full", int'(walmost_full), int'(e.wafull));
                chk("wlevel", int'(wlevel), int'(e.wlevel));
                chk("wovf", int'(wovf), int'(e.wovf));
            end
            if (prev_ok && (wptr != prev_wptr))
                chk("wptr_one_bit_step", $countones(wptr ^ prev_wptr), 1);
            prev_wptr = wptr;
            prev_ok = 1;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        thr_cfg = 14;
        reset_model();

        // Reset with random inputs, then quiet inputs and release away from the edge.
        repeat (5) begin
            @(posedge wclk);
            #1;
            winc = 1'($urandom_range(0, 1));
            wq2_rptr = 5'($urandom_range(0, 31));
            wclr_ovf = 1'($urandom_range(0, 1));
        end
        @(posedge wclk);
        #1;
        winc = 0; wq2_rptr = '0; wclr_ovf = 0;
        @(negedge wclk);
        wrst_n = 1'b1;

        // Fill 16 entries with the read pointer at 0.
        for (int i = 0; i < 16; i++) step(1, 0, 0);
        // Overflow, clear blocked by a failed write, then clear alone.
        step(1, 0, 0);
        step(1, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);
        // Drain through read-pointer updates.
        for (int r = 1; r <= 16; r++) step(0, r, 0);
        // Wrap: 40 writes with the read pointer catching up every fourth cycle.
        for (int k = 0; k < 40; k++) step(1, (k % 4 == 3) ? m_w : m_rd, 0);
        step(0, m_w, 0);
        // Build level 9 for the mid-operation reset.
        for (int k = 0; k < 9; k++) step(1, m_rd, 0);
        step(0, m_rd, 0);

        @(posedge wclk);
        #2;
        chk("pre_reset_wlevel", int'(wlevel), 9);
        wrst_n = 1'b0;
        #1;
        chk("async_rst_waddr", int'(waddr), 0);
        chk("async_rst_wclken", int'(wclken), 0);
        chk("async_rst_wptr", int'(wptr), 0);
        chk("async_rst_wfull", int'(wfull), 0);
        chk("async_rst_walmost_full", int'(walmost_full), 0);
        chk("async_rst_wlevel", int'(wlevel), 0);
        chk("async_rst_wovf", int'(wovf), 0);
        winc = 0; wq2_rptr = '0; wclr_ovf = 0;
        repeat (2) @(negedge wclk);
        wrst_n = 1'b1;
        reset_model();

        // Threshold 0 holds almost-full high even when empty.
        step(0, 0, 0);
        thr_cfg = 0;
        step(0, 0, 0);
        step(0, 0, 0);
        // Threshold 16 rises together with full.
        thr_cfg = 16;
        for (int i = 0; i < 16; i++) step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);

        repeat (3) @(negedge wclk);
        #1;
        if (exp_q.size() != 0) chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
